osd_rom_rr_arbiter: RTL and testbench
=====================================

Name: osd_rom_rr_arbiter

Overview:
- Round-robin arbiter that shares one single-port OSD font ROM among PORT_NUM char_display instances in the UI overlay chain.
- Each requester presents a level request and a glyph address. The arbiter grants one requester per cycle and drives the ROM. It routes the returned word back to the granted port with a one-hot valid.
- It sits between the char_display read ports and the font ROM, in the pclk domain.

Parameters:
- PORT_NUM, 10, number of requesters (2..16).
- AW, 13, ROM address width.
- DW, 16, ROM data width.
- ROM_LAT, 1, cycles from o_rom_en/o_rom_addr to i_rom_data valid (1..4).

Ports:
- pclk  in  1  pixel clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  PORT_NUM  per-port read request (level); bit k belongs to port k.
- i_addr  in  PORT_NUM*AW  packed addresses; port k uses bits [k*AW +: AW].
- o_gnt  out  PORT_NUM  one-hot grant, registered, one cycle wide.
- o_rom_en  out  1  ROM read enable, registered.
- o_rom_addr  out  AW  ROM address, registered.
- i_rom_data  in  DW  ROM read data.
- o_rd_valid  out  PORT_NUM  one-hot return valid, registered.
- o_rd_data  out  DW  returned word, registered, broadcast to all ports.

Behaviour:
- Reset (async assert, sync release):
  - o_gnt, o_rom_en, o_rom_addr, o_rd_valid and o_rd_data are all 0.
  - Priority pointer is 0, so port 0 has highest priority.
  - The tag pipeline is cleared.
- Eligible set: i_req & ~o_gnt. A port whose grant is visible this cycle is masked, so one held request cannot be granted twice. A requester must drop or replace its request in the cycle after o_gnt.
- Selection: the first eligible port scanning upward from ptr, wrapping PORT_NUM-1 -> 0.
- On the edge after selecting port k:
  - o_gnt[k]=1, o_rom_en=1, o_rom_addr=addr[k].
  - ptr becomes (k+1) mod PORT_NUM.
- If no port is eligible:
  - o_gnt=0 and o_rom_en=0.
  - o_rom_addr holds its last value and ptr is unchanged.
- Grant latency: a request that is visible at edge N, and wins, is granted in the cycle after edge N. Throughput is one grant per cycle.
- Fairness: a continuously asserting port is granted within PORT_NUM cycles of assertion, under any load.
- Return path:
  - A tag pipeline of depth ROM_LAT carries {valid, port id} alongside the ROM.
  - If o_rom_en is high in cycle C, i_rom_data is sampled at the end of cycle C+ROM_LAT.
  - In cycle C+ROM_LAT+1, o_rd_valid[id]=1 and o_rd_data=i_rom_data.
  - Total latency from o_gnt to o_rd_valid is ROM_LAT+1 cycles.
  - Back-to-back grants give back-to-back returns in grant order.
- o_rd_data holds its last value while o_rd_valid=0. o_rd_valid is never multi-hot.
- Simultaneous events:
  - A port may receive o_rd_valid for an old read while o_gnt is asserted for a new one. Both are honoured independently.
  - A request that deasserts before it is granted is dropped with no side effects.
- Reset mid-operation: in-flight reads are discarded, with no o_rd_valid after reset release. Requesters restart their requests.
- Configuration rules:
  - PORT_NUM=1 is illegal.
  - ROM_LAT=0 is illegal; use a registered ROM.
  - i_addr of unrequested ports is don't-care.

Test Plan:
- Single request: port 3 asserts with addr 0x0123 at cycle 0, ROM_LAT=1, ROM returns addr^0xFFFF. Required:
  - cycle 1: o_gnt=0x008, o_rom_addr=0x0123.
  - cycle 3: o_rd_valid=0x008, o_rd_data=0xFEDC.
  - No regrant while port 3 holds i_req during its grant cycle.
- All contend: all 10 ports held high from reset with distinct addresses. Required:
  - grants cycle ports 0,1,...,9,0 one per cycle.
  - every o_rd_valid is one-hot and matches its port and address after 2 cycles.
- Pointer wrap: ptr=9 (after a grant to port 8), requests from ports 2 and 5. Required:
  - port 2 is granted first, then port 5.
  - ptr ends at 6.
- Idle gaps: requests from port 7 only, in alternating cycles. Required:
  - o_rom_en pulses only in grant cycles.
  - o_rom_addr and o_rd_data hold during idle cycles.
  - ptr=8 after each grant.
- Latency sweep: ROM_LAT=3, 4 back-to-back grants. Required: 4 consecutive o_rd_valid pulses starting 4 cycles after the first grant, in grant order.
- Reset mid-flight: assert rst while 2 reads are in flight. Required:
  - all outputs are 0 immediately (async).
  - no o_rd_valid after release.
  - the first grant after release goes to the lowest-numbered requesting port.

Source files
------------

// File: rtl/osd_rom_rr_arbiter.sv
// Round-robin arbiter sharing one single-port OSD font ROM among PORT_NUM
// char_display readers; returns each ROM word to its requester with a one-hot valid.
module osd_rom_rr_arbiter #(
  parameter int PORT_NUM = 10,
  parameter int AW       = 13,
  parameter int DW       = 16,
  parameter int ROM_LAT  = 1
) (
  input  logic                   pclk,
  input  logic                   rst,
  input  logic [PORT_NUM-1:0]    i_req,
  input  logic [PORT_NUM*AW-1:0] i_addr,
  output logic [PORT_NUM-1:0]    o_gnt,
  output logic                   o_rom_en,
  output logic [AW-1:0]          o_rom_addr,
  input  logic [DW-1:0]          i_rom_data,
  output logic [PORT_NUM-1:0]    o_rd_valid,
  output logic [DW-1:0]          o_rd_data
);

  localparam int PW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

  // Handshake: i_req[k] is a level request; o_gnt[k] is a one-cycle pulse that
  // accepts it. The port must drop or replace i_req[k] in the cycle after o_gnt[k].
  // Its data comes back ROM_LAT+1 cycles after o_gnt[k] as o_rd_valid[k].
  logic [PW-1:0]               r_ptr;
  logic [PW-1:0]               r_gnt_id;
  logic [PORT_NUM-1:0]         r_gnt;
  logic                        r_rom_en;
  logic [AW-1:0]               r_rom_addr;
  logic [ROM_LAT-1:0]          r_tag_v;
  logic [ROM_LAT-1:0][PW-1:0]  r_tag_id;
  logic [PORT_NUM-1:0]         r_rd_valid;
  logic [DW-1:0]               r_rd_data;

  logic [PORT_NUM-1:0]         w_elig;
  logic                        w_found;
  logic [PW-1:0]               w_sel;
  logic [PW-1:0]               w_ptr_nxt;
  logic [PORT_NUM-1:0]         w_sel_oh;
  logic [AW-1:0]               w_sel_addr;
  logic [PORT_NUM-1:0]         w_ret_oh;

  // A grant visible this cycle masks its own port so a held request is not served twice.
  assign w_elig = i_req & ~r_gnt;

  always_comb begin : p_select
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      idx = int'(r_ptr) + i;
      if (idx >= PORT_NUM) idx = idx - PORT_NUM;
      if (!w_found && w_elig[idx]) begin
        w_found = 1'b1;
        w_sel   = PW'(idx);
      end
    end
  end

  assign w_ptr_nxt  = (w_sel == PW'(PORT_NUM - 1)) ? '0 : w_sel + 1'b1;
  assign w_sel_oh   = {{(PORT_NUM-1){1'b0}}, 1'b1} << w_sel;
  assign w_sel_addr = i_addr[int'(w_sel)*AW +: AW];
  assign w_ret_oh   = {{(PORT_NUM-1){1'b0}}, 1'b1} << r_tag_id[ROM_LAT-1];

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_ptr      <= '0;
      r_gnt_id   <= '0;
      r_gnt      <= '0;
      r_rom_en   <= 1'b0;
      r_rom_addr <= '0;
      r_tag_v    <= '0;
      r_tag_id   <= '0;
      r_rd_valid <= '0;
      r_rd_data  <= '0;
    end else begin
      r_gnt    <= w_found ? w_sel_oh : '0;
      r_rom_en <= w_found;
      if (w_found) begin
        r_rom_addr <= w_sel_addr;
        r_gnt_id   <= w_sel;
        r_ptr      <= w_ptr_nxt;
      end
      // Tag stage j is visible j+1 cycles after the ROM enable it tracks.
      r_tag_v[0]  <= r_rom_en;
      r_tag_id[0] <= r_gnt_id;
      for (int j = 1; j < ROM_LAT; j++) begin
        r_tag_v[j]  <= r_tag_v[j-1];
        r_tag_id[j] <= r_tag_id[j-1];
      end
      r_rd_valid <= r_tag_v[ROM_LAT-1] ? w_ret_oh : '0;
      if (r_tag_v[ROM_LAT-1]) r_rd_data <= i_rom_data;
    end
  end

  assign o_gnt      = r_gnt;
  assign o_rom_en   = r_rom_en;
  assign o_rom_addr = r_rom_addr;
  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = r_rd_data;

endmodule

// File: tb/tb_osd_rom_rr_arbiter.sv
// Bench for osd_rom_rr_arbiter: two instances (ROM_LAT=1 and 3) share one stimulus
// stream and are checked against a round-robin reference model with return queues.
module tb_osd_rom_rr_arbiter;
  localparam int P  = 10;
  localparam int AW = 13;
  localparam int DW = 16;
  localparam int EW = 36;  // {due[15:0], port[3:0], data[15:0]}

  // ---------------- clock / reset ----------------
  logic pclk = 1'b0;
  logic rst  = 1'b0;
  always #5 pclk = ~pclk;

  logic [P-1:0]    req;
  logic [P*AW-1:0] addr;

  logic [P-1:0]  gnt1, gnt3, rdv1, rdv3;
  logic          en1, en3;
  logic [AW-1:0] ra1, ra3;
  logic [DW-1:0] rom_data1, rom_data3, rdd1, rdd3;

  osd_rom_rr_arbiter #(.PORT_NUM(P), .AW(AW), .DW(DW), .ROM_LAT(1)) dut1 (
    .pclk(pclk), .rst(rst), .i_req(req), .i_addr(addr),
    .o_gnt(gnt1), .o_rom_en(en1), .o_rom_addr(ra1), .i_rom_data(rom_data1),
    .o_rd_valid(rdv1), .o_rd_data(rdd1)
  );

  osd_rom_rr_arbiter #(.PORT_NUM(P), .AW(AW), .DW(DW), .ROM_LAT(3)) dut3 (
    .pclk(pclk), .rst(rst), .i_req(req), .i_addr(addr),
    .o_gnt(gnt3), .o_rom_en(en3), .o_rom_addr(ra3), .i_rom_data(rom_data3),
    .o_rd_valid(rdv3), .o_rd_data(rdd3)
  );

  function automatic logic [DW-1:0] romf(input logic [AW-1:0] a);
    return {3'b000, a} ^ 16'hFFFF;
  endfunction

  // Registered font ROMs with latency 1 and 3.
  logic [DW-1:0] rom1_q;
  logic [DW-1:0] rom3_q [3];
  always @(posedge pclk) begin
    rom1_q    <= romf(ra1);
    rom3_q[0] <= romf(ra3);
    rom3_q[1] <= rom3_q[0];
    rom3_q[2] <= rom3_q[1];
  end
  assign rom_data1 = rom1_q;
  assign rom_data3 = rom3_q[2];

  // ---------------- reference model / scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [P-1:0]  m_gnt;
  logic          m_rom_en;
  logic [AW-1:0] m_rom_addr;
  int            m_ptr;
  logic [DW-1:0] m_data1, m_data3;
  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] exp_q3[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_gnt      = '0;
    m_rom_en   = 1'b0;
    m_rom_addr = '0;
    m_ptr      = 0;
    m_data1    = '0;
    m_data3    = '0;
    exp_q1.delete();
    exp_q3.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt1"}, 64'(gnt1), 64'(0));
    chk({tag, "_en1"},  64'(en1),  64'(0));
    chk({tag, "_ra1"},  64'(ra1),  64'(0));
    chk({tag, "_rdv1"}, 64'(rdv1), 64'(0));
    chk({tag, "_rdd1"}, 64'(rdd1), 64'(0));
    chk({tag, "_gnt3"}, 64'(gnt3), 64'(0));
    chk({tag, "_en3"},  64'(en3),  64'(0));
    chk({tag, "_ra3"},  64'(ra3),  64'(0));
    chk({tag, "_rdv3"}, 64'(rdv3), 64'(0));
    chk({tag, "_rdd3"}, 64'(rdd3), 64'(0));
  endtask

  // Called at posedge+1: asserts reset mid-cycle, checks outputs clear at once,
  // then releases it just after the next rising edge.
  task automatic apply_reset(input string tag);
    req = '0;
    #2 rst = 1'b1;
    #1 chk_zero(tag);
    @(posedge pclk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic check_all();
    logic [P-1:0] ev;
    chk("gnt1", 64'(gnt1), 64'(m_gnt));
    chk("gnt3", 64'(gnt3), 64'(m_gnt));
    chk("rom_en1", 64'(en1), 64'(m_rom_en));
    chk("rom_en3", 64'(en3), 64'(m_rom_en));
    chk("rom_addr1", 64'(ra1), 64'(m_rom_addr));
    chk("rom_addr3", 64'(ra3), 64'(m_rom_addr));
    ev = '0;
    if (exp_q1.size() > 0 && exp_q1[0][35:20] == 16'(cyc)) begin
      ev      = P'(1) << exp_q1[0][19:16];
      m_data1 = exp_q1[0][15:0];
      void'(exp_q1.pop_front());
    end
    chk("rd_valid1", 64'(rdv1), 64'(ev));
    chk("rd_data1", 64'(rdd1), 64'(m_data1));
    chk("rd_onehot1", 64'($countones(rdv1) <= 1), 64'(1));
    ev = '0;
    if (exp_q3.size() > 0 && exp_q3[0][35:20] == 16'(cyc)) begin
      ev      = P'(1) << exp_q3[0][19:16];
      m_data3 = exp_q3[0][15:0];
      void'(exp_q3.pop_front());
    end
    chk("rd_valid3", 64'(rdv3), 64'(ev));
    chk("rd_data3", 64'(rdd3), 64'(m_data3));
    chk("rd_onehot3", 64'($countones(rdv3) <= 1), 64'(1));
  endtask

  // One clock: predict the grant from the current inputs, clock, then compare.
  task automatic cycle();
    logic [P-1:0] elig;
    int win;
    elig = req & ~m_gnt;
    win  = -1;
    for (int i = 0; i < P; i++) begin
      if (win < 0 && elig[(m_ptr + i) % P]) win = (m_ptr + i) % P;
    end
    if (win >= 0) begin
      m_gnt      = P'(1) << win;
      m_rom_en   = 1'b1;
      m_rom_addr = addr[win*AW +: AW];
      m_ptr      = (win + 1) % P;
      exp_q1.push_back({16'(cyc + 3), 4'(win), romf(m_rom_addr)});
      exp_q3.push_back({16'(cyc + 5), 4'(win), romf(m_rom_addr)});
    end else begin
      m_gnt    = '0;
      m_rom_en = 1'b0;
    end
    @(posedge pclk);
    #1 cyc++;
    check_all();
  endtask

  task automatic idle(input int n);
    req = '0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic rand_addr();
    for (int k = 0; k < P; k++) addr[k*AW +: AW] = AW'($urandom_range(0, 8191));
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    req  = '0;
    addr = '0;
    model_reset();
    apply_reset("reset");

    // Single request from port 3
    rand_addr();
    addr[3*AW +: AW] = 13'h0123;
    req = P'(1) << 3;
    cycle();
    chk("single_gnt", 64'(gnt1), 64'(10'h008));
    chk("single_addr", 64'(ra1), 64'(13'h0123));
    cycle();
    chk("single_noregrant", 64'(gnt1), 64'(0));
    req = '0;
    cycle();
    chk("single_rdv", 64'(rdv1), 64'(10'h008));
    chk("single_rdd", 64'(rdd1), 64'(16'hFEDC));
    idle(5);

    // All ports contend from reset
    apply_reset("reset2");
    for (int k = 0; k < P; k++) addr[k*AW +: AW] = AW'(k * 37 + 5);
    req = '1;
    for (int i = 0; i <= P; i++) begin
      cycle();
      chk("contend_gnt", 64'(gnt1), 64'(P'(1) << (i % P)));
      if (i >= 2) begin
        chk("contend_rdv1", 64'(rdv1), 64'(P'(1) << ((i - 2) % P)));
        chk("contend_rdd1", 64'(rdd1), 64'(romf(AW'(((i - 2) % P) * 37 + 5))));
      end
      if (i >= 4) begin
        chk("lat3_rdv", 64'(rdv3), 64'(P'(1) << ((i - 4) % P)));
        chk("lat3_rdd", 64'(rdd3), 64'(romf(AW'(((i - 4) % P) * 37 + 5))));
      end
    end
    idle(6);

    // Pointer wrap: grant port 8, then ports 2 and 5 compete
    rand_addr();
    req = P'(1) << 8;
    cycle();
    chk("wrap_gnt8", 64'(gnt1), 64'(P'(1) << 8));
    req = (P'(1) << 2) | (P'(1) << 5);
    cycle();
    chk("wrap_gnt2", 64'(gnt1), 64'(P'(1) << 2));
    cycle();
    chk("wrap_gnt5", 64'(gnt1), 64'(P'(1) << 5));
    req = (P'(1) << 0) | (P'(1) << 6);
    cycle();
    chk("wrap_ptr6", 64'(gnt1), 64'(P'(1) << 6));
    idle(2);

    // Idle gaps: port 7 on alternate cycles
    for (int k = 0; k < 4; k++) begin
      rand_addr();
      req = P'(1) << 7;
      cycle();
      chk("gap_en", 64'(en1), 64'(1));
      chk("gap_gnt", 64'(gnt1), 64'(P'(1) << 7));
      req = '0;
      rand_addr();
      cycle();
      chk("gap_idle_en", 64'(en1), 64'(0));
    end
    req = (P'(1) << 7) | (P'(1) << 8);
    cycle();
    chk("gap_ptr8", 64'(gnt1), 64'(P'(1) << 8));
    idle(6);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_addr();
      if ($urandom_range(0, 3) == 0) req = '1;
      else req = P'($urandom) & P'($urandom);
      cycle();
    end
    idle(6);

    // Reset with two reads in flight
    rand_addr();
    req = (P'(1) << 4) | (P'(1) << 6);
    cycle();
    cycle();
    apply_reset("midrst");
    req = (P'(1) << 9) | (P'(1) << 3) | (P'(1) << 5);
    cycle();
    chk("post_rst_first", 64'(gnt1), 64'(P'(1) << 3));
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
